// File: rtl/ball_engine.sv
// ball_engine: Pong ball motion, wall/paddle bounces, scoring and serve/score/over FSM.
// Define BALL_AI_EN to build the registered computer-paddle tracker on ai_y (else ai_y = 0).
module ball_engine #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int BALL_SIZE  = 5,
    parameter int PADDLE_W   = 10,
    parameter int PADDLE_H   = 120,
    parameter int TICK_DIV   = 125000,
    parameter int SPEED_MAX  = 4,
    parameter int HOLD_TICKS = 60,
    parameter int WIN_SCORE  = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serve,
    input  logic [9:0] p1_x,
    input  logic [9:0] p1_y,
    input  logic [9:0] p2_x,
    input  logic [9:0] p2_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic       game_over,
    output logic       tick,
    output logic [9:0] ai_y
);

    localparam int DIV_W  = $clog2(TICK_DIV);
    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam int SPD_W  = $clog2(SPEED_MAX + 1);
    localparam int SPW1   = SPD_W + 1;

    localparam logic [9:0]  CX    = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0]  CY    = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [10:0] X_MAX = 11'(H_ACTIVE - BALL_SIZE);
    localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - BALL_SIZE);
    localparam logic [10:0] BS11  = 11'(BALL_SIZE);
    localparam logic [10:0] PW11  = 11'(PADDLE_W);
    localparam logic [10:0] PH11  = 11'(PADDLE_H);
    localparam logic [3:0]  WIN4  = 4'(WIN_SCORE);
    localparam logic [SPD_W-1:0]  SPD_ONE  = SPD_W'(1);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_SCORED, S_OVER} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [9:0]        x_q, x_d, y_q, y_d;
    logic              dx_q, dx_d, dy_q, dy_d;
    logic [SPD_W-1:0]  speed_q, speed_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [3:0]        p1s_q, p1s_d, p2s_q, p2s_d;

    logic        tick_w;
    logic [10:0] x11, y11, spd11, p1x11, p1y11, p2x11, p2y11;
    logic [10:0] ny, nx_move;
    logic        ndy, hit_l, hit_r, miss_l, miss_r;
    logic [3:0]  p1s_inc, p2s_inc;

    function automatic logic [9:0] clamp_pos(input logic [10:0] v, input logic [10:0] lim);
        if (v > lim) clamp_pos = lim[9:0];
        else         clamp_pos = v[9:0];
    endfunction

    function automatic logic [SPD_W-1:0] speed_up(input logic [SPD_W-1:0] s);
        logic [SPD_W:0] inc;
        inc = {1'b0, s} + SPW1'(1);
        if (inc > SPW1'(SPEED_MAX)) speed_up = SPD_W'(SPEED_MAX);
        else                        speed_up = inc[SPD_W-1:0];
    endfunction

    assign tick_w = (div_q == DIV_LAST);

    // Candidate motion for this tick: vertical first, then paddle/miss tests on the new y.
    always_comb begin
        x11   = {1'b0, x_q};
        y11   = {1'b0, y_q};
        spd11 = 11'(speed_q);
        p1x11 = {1'b0, p1_x};
        p1y11 = {1'b0, p1_y};
        p2x11 = {1'b0, p2_x};
        p2y11 = {1'b0, p2_y};

        ndy = dy_q;
        if (!dy_q && (y11 <= spd11)) begin
            ny  = '0;
            ndy = 1'b1;
        end else if (dy_q && (y11 + spd11 >= Y_MAX)) begin
            ny  = Y_MAX;
            ndy = 1'b0;
        end else if (dy_q) begin
            ny = y11 + spd11;
        end else begin
            ny = y11 - spd11;
        end

        hit_l = !dx_q && (x11 <= p1x11 + PW11) && (x11 + BS11 > p1x11)
                && (ny + BS11 > p1y11) && (ny < p1y11 + PH11);
        hit_r =  dx_q && (x11 + BS11 >= p2x11) && (x11 < p2x11 + PW11)
                && (ny + BS11 > p2y11) && (ny < p2y11 + PH11);
        miss_l = !hit_l && !dx_q && (x11 <= spd11);
        miss_r = !hit_r &&  dx_q && (x11 + spd11 >= X_MAX);

        nx_move = dx_q ? (x11 + spd11) : (x11 - spd11);
        p1s_inc = p1s_q + 4'd1;
        p2s_inc = p2s_q + 4'd1;
    end

    always_comb begin
        state_d = state_q;
        div_d   = tick_w ? '0 : div_q + DIV_W'(1);
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        speed_d = speed_q;
        hold_d  = hold_q;
        p1s_d   = p1s_q;
        p2s_d   = p2s_q;

        case (state_q)
            S_IDLE: begin
                x_d     = CX;
                y_d     = CY;
                speed_d = SPD_ONE;
                if (serve) begin
                    state_d = S_PLAY;
                    dy_d    = ~dy_q;
                end
            end
            S_PLAY: begin
                if (tick_w) begin
                    // A miss re-centres the ball, so the vertical result of this tick is dropped.
                    if (miss_l || miss_r) begin
                        x_d    = CX;
                        y_d    = CY;
                        hold_d = '0;
                        dx_d   = miss_r;
                        if (miss_l) begin
                            p2s_d   = p2s_inc;
                            state_d = (p2s_inc == WIN4) ? S_OVER : S_SCORED;
                        end else begin
                            p1s_d   = p1s_inc;
                            state_d = (p1s_inc == WIN4) ? S_OVER : S_SCORED;
                        end
                    end else begin
                        y_d  = clamp_pos(ny, Y_MAX);
                        dy_d = ndy;
                        if (hit_l) begin
                            x_d     = clamp_pos(p1x11 + PW11, X_MAX);
                            dx_d    = 1'b1;
                            speed_d = speed_up(speed_q);
                        end else if (hit_r) begin
                            x_d     = (p2x11 >= BS11) ? clamp_pos(p2x11 - BS11, X_MAX) : 10'd0;
                            dx_d    = 1'b0;
                            speed_d = speed_up(speed_q);
                        end else begin
                            x_d = clamp_pos(nx_move, X_MAX);
                        end
                    end
                end
            end
            S_SCORED: begin
                x_d = CX;
                y_d = CY;
                if (tick_w) begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = S_PLAY;
                        hold_d  = '0;
                        speed_d = SPD_ONE;
                        dy_d    = ~dy_q;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            S_OVER: begin
                x_d = CX;
                y_d = CY;
                if (serve) begin
                    state_d = S_IDLE;
                    p1s_d   = '0;
                    p2s_d   = '0;
                    speed_d = SPD_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            x_q     <= CX;
            y_q     <= CY;
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            speed_q <= SPD_ONE;
            hold_q  <= '0;
            p1s_q   <= '0;
            p2s_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            speed_q <= speed_d;
            hold_q  <= hold_d;
            p1s_q   <= p1s_d;
            p2s_q   <= p2s_d;
        end
    end

    assign ball_x    = x_q;
    assign ball_y    = y_q;
    assign p1_score  = p1s_q;
    assign p2_score  = p2s_q;
    assign game_over = (state_q == S_OVER);
    assign tick      = tick_w;

`ifdef BALL_AI_EN
    localparam logic signed [12:0] AI_OFS = 13'(BALL_SIZE / 2 - PADDLE_H / 2);
    localparam logic signed [12:0] AI_MAX = 13'(V_ACTIVE - PADDLE_H);
    localparam logic [9:0]         AI_RST = 10'((V_ACTIVE - PADDLE_H) / 2);

    logic [9:0] ai_q, ai_d;

    // Centre the paddle on the ball's new position, kept fully on screen.
    function automatic logic [9:0] ai_track(input logic [9:0] by);
        logic signed [12:0] t;
        t = $signed({3'b000, by}) + AI_OFS;
        if (t < 13'sd0)       ai_track = 10'd0;
        else if (t > AI_MAX)  ai_track = AI_MAX[9:0];
        else                  ai_track = t[9:0];
    endfunction

    always_comb begin
        ai_d = ai_q;
        if (tick_w) ai_d = ai_track(y_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ai_q <= AI_RST;
        else       ai_q <= ai_d;
    end

    assign ai_y = ai_q;
`else
    assign ai_y = 10'd0;
`endif

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine with TICK_DIV=4: expected ball positions queued as a
// scoreboard when a step is launched and popped/compared once the ticks have elapsed.
module tb_ball_engine;

    logic       clk = 1'b0;
    logic       reset, serve;
    logic [9:0] p1_x, p1_y, p2_x, p2_y;
    logic [9:0] ball_x, ball_y, ai_y;
    logic [3:0] p1_score, p2_score;
    logic       game_over, tick;

    always #5 clk = ~clk;

    ball_engine #(.TICK_DIV(4)) dut (
        .clk(clk), .reset(reset), .serve(serve),
        .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
        .ball_x(ball_x), .ball_y(ball_y),
        .p1_score(p1_score), .p2_score(p2_score),
        .game_over(game_over), .tick(tick), .ai_y(ai_y)
    );

`ifdef BALL_AI_EN
    localparam int AI_RESET = 180;
    localparam int AI_T30   = 110;
`else
    localparam int AI_RESET = 0;
    localparam int AI_T30   = 0;
`endif

    typedef struct {
        string tag;
        int    x;
        int    y;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    endtask

    task automatic step_tick();
        int n = 0;
        while (tick !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (tick !== 1'b1) begin
            n_checks++;
            $error("FAIL tick_timeout: tick=%b, expected 1 within 16 clk", tick);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) step_tick();
    endtask

    task automatic expect_after(input string tag, input int nticks, input int x, input int y);
        exp_t e;
        sb.push_back('{tag, x, y});
        run_ticks(nticks);
        e = sb.pop_front();
        chk({e.tag, ".x"}, 32'(ball_x), e.x);
        chk({e.tag, ".y"}, 32'(ball_y), e.y);
    endtask

    task automatic pulse_serve(input logic want_tick);
        int n = 0;
        @(negedge clk);
        while (tick !== want_tick && n < 16) begin
            @(negedge clk);
            n++;
        end
        if (tick !== want_tick) begin
            n_checks++;
            $error("FAIL serve_align: tick=%b, expected %b", tick, want_tick);
        end
        serve = 1'b1;
        @(posedge clk);
        #1;
        serve = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks_seen;
        reset = 1'b1;
        serve = 1'b0;
        p1_x  = 10'd0;   p1_y = 10'd0;
        p2_x  = 10'd700; p2_y = 10'd0;
        #12;
        chk("rst.x", ball_x, 317);
        chk("rst.y", ball_y, 237);
        chk("rst.p1", p1_score, 0);
        chk("rst.p2", p2_score, 0);
        chk("rst.go", game_over, 0);
        chk("rst.tick", tick, 0);
        chk("rst.ai", ai_y, AI_RESET);

        // Idle: tick every 4 clk, ball parked at centre.
        @(negedge clk);
        reset = 1'b0;
        ticks_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tick === 1'b1) ticks_seen++;
        end
        chk("idle.ticks", ticks_seen, 10);
        chk("idle.x", ball_x, 317);
        chk("idle.y", ball_y, 237);

        // Nine straight right-side misses: each rally is 317 moving ticks then the miss.
        pulse_serve(1'b0);
        chk("serve.x", ball_x, 317);
        for (int pt = 1; pt <= 9; pt++) begin
            expect_after("rally_t1", 1, 318, 236);
            expect_after("pre_miss", 316, 634, 80);
            expect_after("miss", 1, 317, 237);
            chk("miss.p1", p1_score, pt);
            chk("miss.p2", p2_score, 0);
            chk("miss.go", game_over, (pt == 9));
            if (pt < 9) begin
                if (pt == 1) begin
                    run_ticks(10);
                    pulse_serve(1'b0);
                    expect_after("hold_serve_ignored", 49, 317, 237);
                end else begin
                    expect_after("hold", 59, 317, 237);
                end
                expect_after("reserve", 1, 317, 237);
            end
        end

        expect_after("over_frozen", 5, 317, 237);
        chk("over.go", game_over, 1);
        chk("over.p1", p1_score, 9);
        pulse_serve(1'b0);
        chk("restart.p1", p1_score, 0);
        chk("restart.p2", p2_score, 0);
        chk("restart.go", game_over, 0);
        expect_after("idle_again", 3, 317, 237);

        // Score once, re-serve, then reset asynchronously mid-flight.
        pulse_serve(1'b0);
        run_ticks(318);
        chk("rerun.p1", p1_score, 1);
        run_ticks(60);
        expect_after("mid_flight", 5, 322, 232);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("async.x", ball_x, 317);
        chk("async.y", ball_y, 237);
        chk("async.p1", p1_score, 0);
        chk("async.go", game_over, 0);
        chk("async.tick", tick, 0);
        chk("async.ai", ai_y, AI_RESET);
        @(negedge clk);
        reset = 1'b0;

        // Paddle rally near centre: speed climbs 1->2->3->4 and saturates.
        p1_x = 10'd300; p1_y = 10'd150;
        p2_x = 10'd330; p2_y = 10'd150;
        pulse_serve(1'b1);
        chk("serve_on_tick.x", ball_x, 317);
        chk("serve_on_tick.y", ball_y, 237);
        expect_after("hit_r1", 9, 325, 228);
        expect_after("hit_l1", 9, 310, 210);
        expect_after("hit_r2", 6, 325, 192);
        expect_after("hit_l_sat", 5, 310, 172);
        expect_after("speed_sat", 1, 314, 168);
        chk("ai_t30", ai_y, AI_T30);
        p1_y = 10'd60; p2_y = 10'd60;
        expect_after("pp_mid", 24, 325, 72);
        p1_y = 10'd0; p2_y = 10'd0;
        expect_after("wall_pre", 17, 318, 4);
        expect_after("wall_top", 1, 322, 0);
        chk("ai_top", ai_y, 0);
        expect_after("wall_down", 1, 326, 4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
